serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Deserialising receiver directly downstream of the universal shift register's serial output (sout in PISO/SISO modes).
- Samples one bit per qualified clock, frames it as start / N data (LSB first) / optional even parity / stop, checks it and presents the word on a valid/ready parallel port.
- Sits between the serial link and the consuming parallel logic.

Parameters:
- N, 5, data bits per frame (N >= 2).
- PARITY_EN, 1, 1 = even parity bit present after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- sin  input  1  serial line, idle high; driven by the upstream shift register's sout.
- bit_en  input  1  sample strobe; sin is consumed only on clocks where bit_en=1.
- ready  input  1  downstream accepts q this cycle when valid=1.
- q  output  N  received data word, held stable while valid=1.
- valid  output  1  q holds an unconsumed word.
- busy  output  1  high in every state except IDLE.
- parity_err  output  1  one-cycle pulse on a parity mismatch.
- frame_err  output  1  one-cycle pulse on a stop bit = 0.
- overrun  output  1  one-cycle pulse when a good word is dropped because the output is still full.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - q=0, valid=0, busy=0, parity_err=0, frame_err=0, overrun=0.
  - Bit counter and shift register are cleared.
  - Any partial frame is discarded. Reset mid-frame is legal.
- Clocks with bit_en=0:
  - The receive state machine holds.
  - Handshake and pulse logic still run.
- States and transitions (all taken on a clock with bit_en=1):
  - IDLE: sin=0 goes to DATA with the counter at 0. sin=1 stays in IDLE.
  - DATA: shift sin into the MSB of the shift register and shift right, so the first data bit lands at q[0]. Increment the counter. After the N-th bit, go to PAR if PARITY_EN=1, otherwise to STOP.
  - PAR: capture sin as the parity bit and go to STOP.
  - STOP: evaluate the frame and go to IDLE if sin=1. If sin=0, go to WAIT_IDLE.
  - WAIT_IDLE: stay until sin=1 is sampled, then go to IDLE. This prevents a stuck-low or break line from re-triggering frames.
- Frame evaluation, on the STOP sample edge:
  - Stop bit = 0: frame_err pulses high for the next cycle and the word is discarded.
  - Otherwise, with PARITY_EN=1, a check is made: XOR of the data bits XOR the parity bit must equal 0. On a mismatch, parity_err pulses and the word is discarded.
  - If the stop bit and parity are both bad, only frame_err pulses.
  - Good word with valid=0: q loads and valid=1 from the next cycle. Latency is 1 clock after the stop-bit sample edge.
  - Good word with valid=1 and ready=1 in the same cycle: the old word is consumed, the new word loads, and valid stays 1. No overrun.
  - Good word with valid=1 and ready=0: the new word is dropped, q keeps the old word, and overrun pulses.
- Handshake:
  - The transfer occurs on any clock with valid=1 and ready=1.
  - valid clears on that edge unless a new good word loads in the same cycle.
  - q never changes while valid=1 and no transfer occurs.
  - ready is ignored while valid=0.
- Pulse outputs are registered and high for exactly one clock. They are mutually exclusive per frame.
- busy is registered from the state: busy=1 in DATA, PAR, STOP and WAIT_IDLE.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst=0 after 3 DATA bits, release, then send a clean frame.
  - Required: all outputs are 0 immediately on reset assertion, and the following frame is received correctly.
- Good frame, N=5, PARITY_EN=1, bit_en=1 continuously:
  - Stimulus: sin = 0,0,1,1,0,1,1,1 (start, data 5'b10110 LSB first, parity 1, stop 1), ready=0.
  - Required: q=5'b10110 and valid=1 one clock after the stop sample; no error pulses; busy falls with valid rising.
- Parity error:
  - Stimulus: same frame with the parity bit = 0.
  - Required: parity_err pulses one cycle, valid stays 0, q unchanged.
- Frame error and break:
  - Stimulus: stop bit = 0, then sin held 0 for 10 clocks, then 1, then the good frame from the second scenario.
  - Required: frame_err pulses once, there is no spurious start during the low period, and the word is received after sin returns high.
- Overrun and simultaneous accept:
  - Stimulus: receive 5'b00011 and hold ready=0; send 5'b11100.
  - Required: overrun pulses, q stays 5'b00011.
  - Stimulus: repeat with ready=1 exactly on the second stop-sample cycle.
  - Required: q=5'b11100, valid stays 1, no overrun.
- bit_en gating, PARITY_EN=0 build:
  - Stimulus: bit_en=1 every third clock, frame 0,1,0,1,0,1,1 (data 5'b10101, stop 1).
  - Required: q=5'b10101, and the state holds on every bit_en=0 clock.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserialising receiver for a start / N data (LSB first) /
// optional even parity / stop serial frame, fed by an upstream shift register.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   sin         serial line, idle high
//   bit_en      sample strobe; sin is consumed only when bit_en=1
//   ready       downstream accepts q this cycle when valid=1
//   q           received data word, stable while valid=1
//   valid       q holds an unconsumed word
//   busy        receiver is inside a frame (any state other than IDLE)
//   parity_err  one-cycle pulse on a parity mismatch
//   frame_err   one-cycle pulse on a zero stop bit
//   overrun     one-cycle pulse when a good word is dropped (output full)
module serial_frame_rx #(
    parameter int unsigned N         = 5,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         bit_en,
    input  logic         ready,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         busy,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_shift;
    logic            r_par;
    logic [N-1:0]    r_q;
    logic            r_valid;
    logic            r_busy;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_overrun;

    logic            w_last_bit;
    logic            w_par_ok;
    logic            w_stop_eval;
    logic            w_good;
    logic            w_load;

    // Frame evaluation happens on the qualified stop-bit sample
    assign w_last_bit  = (r_cnt == CW'(N - 1));
    assign w_par_ok    = !PARITY_EN || ((^{r_shift, r_par}) == 1'b0);
    assign w_stop_eval = bit_en && (r_state == S_STOP);
    assign w_good      = w_stop_eval && sin && w_par_ok;
    // A good word loads when the slot is empty or is being drained this cycle
    assign w_load      = w_good && (!r_valid || ready);

    // Receive FSM, output handshake and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_q          <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;

            if (w_load) begin
                r_q     <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            // Frame error dominates parity error; overrun only for good words
            if (w_stop_eval) begin
                if (!sin) begin
                    r_frame_err <= 1'b1;
                end else if (!w_par_ok) begin
                    r_parity_err <= 1'b1;
                end else if (!w_load) begin
                    r_overrun <= 1'b1;
                end
            end

            if (bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!sin) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        // Shift right so the first data bit ends at bit 0
                        r_shift <= {sin, r_shift[N-1:1]};
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last_bit) begin
                            r_state <= PARITY_EN ? S_PAR : S_STOP;
                        end
                    end
                    S_PAR: begin
                        r_par   <= sin;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (sin) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        // A held-low (break) line must not look like a new start
                        if (sin) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q          = r_q;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: self-checking bench for serial_frame_rx.
// dut_a: N=5 with parity; dut_b: N=5 without parity (bit_en gating test).
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       sin_a, en_a, rdy_a;
    logic [4:0] q_a;
    logic       v_a, b_a, pe_a, fe_a, ov_a;
    logic       sin_b, en_b, rdy_b;
    logic [4:0] q_b;
    logic       v_b, b_b, pe_b, fe_b, ov_b;

    int checks = 0;
    int errors = 0;

    serial_frame_rx #(.N(5), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sin(sin_a), .bit_en(en_a), .ready(rdy_a),
        .q(q_a), .valid(v_a), .busy(b_a), .parity_err(pe_a),
        .frame_err(fe_a), .overrun(ov_a)
    );

    serial_frame_rx #(.N(5), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sin(sin_b), .bit_en(en_b), .ready(rdy_b),
        .q(q_b), .valid(v_b), .busy(b_b), .parity_err(pe_b),
        .frame_err(fe_b), .overrun(ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [4:0] qq,
                         input logic b, input logic pe, input logic fe, input logic ov);
        chk({tag, ".valid"}, 32'(v_a), 32'(v));
        chk({tag, ".q"}, 32'(q_a), 32'(qq));
        chk({tag, ".busy"}, 32'(b_a), 32'(b));
        chk({tag, ".parity_err"}, 32'(pe_a), 32'(pe));
        chk({tag, ".frame_err"}, 32'(fe_a), 32'(fe));
        chk({tag, ".overrun"}, 32'(ov_a), 32'(ov));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [4:0] qq,
                         input logic b);
        chk({tag, ".valid"}, 32'(v_b), 32'(v));
        chk({tag, ".q"}, 32'(q_b), 32'(qq));
        chk({tag, ".busy"}, 32'(b_b), 32'(b));
        chk({tag, ".pulses"}, 32'({pe_b, fe_b, ov_b}), 32'(0));
    endtask

    // Drive dut_a inputs, clock once, sample 1 time unit after the edge
    task automatic step(input logic s, input logic e, input logic r);
        sin_a = s;
        en_a  = e;
        rdy_a = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       s, e, r;
        logic       v;
        logic [4:0] q;
        logic       b, pe, fe, ov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic e, input logic r, input logic v,
                                input logic [4:0] qq, input logic b, input logic pe,
                                input logic fe, input logic ov);
        vec_t t;
        t.s = s; t.e = e; t.r = r; t.v = v; t.q = qq;
        t.b = b; t.pe = pe; t.fe = fe; t.ov = ov;
        vecs.push_back(t);
    endfunction

    // seq[n-1] is sent first; every row is an in-frame sample with ready=0
    function automatic void add_busy(input logic [15:0] seq, input int n,
                                     input logic v, input logic [4:0] qq);
        for (int i = n - 1; i >= 0; i--) add(seq[i], 1'b1, 1'b0, v, qq, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    // ---------------- random frames + transaction-level model ----------------
    typedef struct {
        logic       s;
        int         ev;   // 0 none, 1 good word, 2 parity error, 3 frame error
        logic [4:0] w;
        logic       b;    // receiver busy after this sample
    } smp_t;

    smp_t smp[$];
    logic       m_full, m_busy, m_pe, m_fe, m_ov;
    logic [4:0] m_q;

    function automatic void push_s(input logic s, input int ev, input logic [4:0] w, input logic b);
        smp_t t;
        t.s = s; t.ev = ev; t.w = w; t.b = b;
        smp.push_back(t);
    endfunction

    task automatic model_cycle(input bit smpd, input smp_t x, input logic r);
        logic ld;
        ld   = 1'b0;
        m_pe = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (smpd) begin
            m_busy = x.b;
            case (x.ev)
                1: if (!m_full || r) ld = 1'b1; else m_ov = 1'b1;
                2: m_pe = 1'b1;
                3: m_fe = 1'b1;
                default: ;
            endcase
        end
        if (ld) begin
            m_full = 1'b1;
            m_q    = x.w;
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
    endtask

    task automatic run_random(input int nframes);
        logic [4:0] d;
        logic       p;
        logic       r;
        int         kind;
        int         cyc;
        smp_t       none;
        none.s = 1'b1; none.ev = 0; none.w = '0; none.b = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            d    = 5'($urandom);
            kind = int'($urandom_range(0, 3));
            p    = ^d;
            if (kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1)) p = ~p;
            push_s(1'b0, 0, '0, 1'b1);
            for (int i = 0; i < 5; i++) push_s(d[i], 0, '0, 1'b1);
            push_s(p, 0, '0, 1'b1);
            if (kind == 3) begin
                push_s(1'b0, 3, d, 1'b1);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) push_s(1'b0, 0, '0, 1'b1);
                push_s(1'b1, 0, '0, 1'b0);
            end else begin
                push_s(1'b1, (kind == 2) ? 2 : 1, d, 1'b0);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) push_s(1'b1, 0, '0, 1'b0);
        end
        cyc = 0;
        foreach (smp[j]) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                r = ($urandom_range(0, 9) < 3);
                step(1'($urandom_range(0, 1)), 1'b0, r);
                model_cycle(1'b0, none, r);
                chk_a($sformatf("rnd%0d", cyc), m_full, m_q, m_busy, m_pe, m_fe, m_ov);
                cyc++;
            end
            r = ($urandom_range(0, 9) < 3);
            step(smp[j].s, 1'b1, r);
            model_cycle(1'b1, smp[j], r);
            chk_a($sformatf("rnd%0d", cyc), m_full, m_q, m_busy, m_pe, m_fe, m_ov);
            cyc++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] fb;
        logic [7:0] fr;
        logic       eb;

        rst   = 1'b0;
        sin_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
        sin_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0;
        #3;
        chk_a("reset", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_b("reset_b", 1'b0, 5'd0, 1'b0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        // idle gating and ready ignored while empty
        add(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        // good frame 10110, parity 1
        add_busy(16'b0011011, 7, 1'b0, 5'b00000);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        // parity error
        add_busy(16'b0011010, 7, 1'b0, 5'b10110);
        add(1'b1, 1'b1, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        // frame error, 10-sample break, recovery, good frame
        add_busy(16'b0011011, 7, 1'b0, 5'b10110);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'b10110, 1'b1, 1'b0, 1'b1, 1'b0);
        add_busy(16'b0, 10, 1'b0, 5'b10110);
        add(1'b1, 1'b1, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        add_busy(16'b0011011, 7, 1'b0, 5'b10110);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        // 00011 received and held, then 11100 overruns
        add_busy(16'b0110000, 7, 1'b0, 5'b10110);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        add_busy(16'b0001111, 7, 1'b1, 5'b00011);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        // 11100 again with ready=1 on the stop sample: consume + load
        add_busy(16'b0001111, 7, 1'b1, 5'b00011);
        add(1'b1, 1'b1, 1'b1, 1'b1, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].e, vecs[i].r);
            chk_a($sformatf("vec%0d", i), vecs[i].v, vecs[i].q, vecs[i].b,
                  vecs[i].pe, vecs[i].fe, vecs[i].ov);
        end

        // reset mid-frame: start + 3 data bits with a word pending
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_a("pre_rst", 1'b1, 5'b11100, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_a("rst_mid", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        fr = 8'b00110111;
        for (int i = 7; i >= 0; i--) step(fr[i], 1'b1, 1'b0);
        chk_a("post_rst", 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        // transfer with bit_en low: handshake still runs
        step(1'b1, 1'b0, 1'b1);
        chk_a("consume_gated", 1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);

        // bit_en every third clock on the no-parity build
        sin_b = 1'b0; en_b = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk_b("b_idle_gated", 1'b0, 5'd0, 1'b0);
        fb = 7'b0101011;
        eb = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            for (int g = 0; g < 2; g++) begin
                sin_b = ~fb[i];
                en_b  = 1'b0;
                step(1'b1, 1'b0, 1'b0);
                chk_b($sformatf("b_hold%0d_%0d", i, g), 1'b0, 5'd0, eb);
            end
            sin_b = fb[i];
            en_b  = 1'b1;
            step(1'b1, 1'b0, 1'b0);
            eb = (i != 0);
            if (i != 0) chk_b($sformatf("b_bit%0d", i), 1'b0, 5'd0, eb);
        end
        chk_b("b_word", 1'b1, 5'b10101, 1'b0);
        sin_b = 1'b1; en_b = 1'b0; rdy_b = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk_b("b_consume", 1'b0, 5'b10101, 1'b0);
        rdy_b = 1'b0;

        // randomized frames against the transaction model
        m_full = 1'b0;
        m_q    = 5'b10110;
        m_busy = 1'b0;
        run_random(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
